uut_hash_run_sequencer: RTL
===========================

Name: uut_hash_run_sequencer

Overview:
Parametrised multi-run sequencer placed between the autotest controller and a hash UUT, such as the Hirose/PRESENT wrapper.
- Runs the UUT a programmable number of times on a base plaintext, optionally incrementing the plaintext each run.
- Resets the UUT before every run and measures per-run latency in clock cycles.
- Keeps an XOR signature of all hashes, plus min/max/total latency and timeout detection, for readback by the controller.

Parameters:
DATA_WIDTH, 64, plaintext width
HASH_WIDTH, 128, hash output width
CNT_WIDTH, 32, latency counter and statistics width
RUNS_WIDTH, 16, width of run-count fields
RST_CYCLES, 4, cycles the UUT reset is held before each run (>=1)
TIMEOUT, 1048576, max RUN cycles before abort (< 2^CNT_WIDTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start_i  in  1  start pulse; sampled only in IDLE
runs_i  in  RUNS_WIDTH  number of runs; 0 treated as 1
plaintext_i  in  DATA_WIDTH  base plaintext, latched on start
incr_i  in  1  1: plaintext +1 after each run; latched on start
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse at end of sequence
timeout_o  out  1  sticky; cleared on next accepted start
rst_uut_o  out  1  active-high UUT reset
plaintext_uut_o  out  DATA_WIDTH  plaintext driven to UUT
hash_uut_i  in  HASH_WIDTH  UUT hash output
end_signal_uut_i  in  1  UUT completion flag (level)
hash_last_o  out  HASH_WIDTH  hash of most recent completed run
signature_o  out  HASH_WIDTH  XOR of all captured hashes
runs_done_o  out  RUNS_WIDTH  completed runs
cycles_last_o  out  CNT_WIDTH  latency of last run
cycles_min_o  out  CNT_WIDTH  minimum latency
cycles_max_o  out  CNT_WIDTH  maximum latency
cycles_total_o  out  CNT_WIDTH  summed latency, saturating

Behaviour:
Reset (rst=0 at a clock edge):
- State goes to IDLE.
- rst_uut_o=1; every other output and register is 0.

FSM states: IDLE, RST_UUT, RUN, CAPTURE, DONE.

IDLE:
- rst_uut_o=1.
- On start_i=1:
  - latch runs (0 becomes 1), plaintext_i and incr_i;
  - clear signature, runs_done, last, max and total; set min to all-ones; clear timeout;
  - go to RST_UUT.
- start_i in any other state is ignored.

RST_UUT:
- rst_uut_o=1 for exactly RST_CYCLES cycles, then RUN.
- plaintext_uut_o is stable from the first RST_UUT cycle until CAPTURE.
- end_signal_uut_i is ignored.

RUN:
- rst_uut_o=0. Latency counter is 1 on the first RUN cycle and increments each cycle.
- end_signal_uut_i=1 in a RUN cycle: latency = counter value in that cycle; go to CAPTURE.
- If the counter equals TIMEOUT and end_signal_uut_i=0: set timeout_o=1, drop remaining runs, go to DONE. Nothing from this run is captured.
- end_signal and timeout in the same cycle: end wins.

CAPTURE (1 cycle; rst_uut_o=1):
- hash_last <= hash_uut_i
- signature ^= hash_uut_i
- cycles_last <= latency
- min/max update
- total += latency, saturating at all-ones
- runs_done += 1
- If runs_done+1 == latched runs, go to DONE. Otherwise go to RST_UUT; if incr, plaintext += 1 modulo 2^DATA_WIDTH (wraps).

DONE:
- done_o=1 for one cycle, rst_uut_o=1, then IDLE.

Timing and result registers:
- A UUT with latency L gives RST_CYCLES + L + 1 cycles per run.
- done_o pulses 1 cycle after the last CAPTURE.
- Results hold after DONE until the next accepted start.
- Reset mid-sequence aborts immediately: no done_o pulse, rst_uut_o=1.

Test Plan:
1. UUT model L=10, runs_i=1, plaintext 0x0123456789ABCDEF, incr=0 -> rst_uut_o high for 4 cycles; done_o 16 cycles after start; cycles_last/min/max/total=10; signature==hash_last; runs_done=1.
2. runs_i=3, incr=1, plaintext 0xFFFFFFFFFFFFFFFF, model latencies 7, 12, 9 -> UUT sees plaintexts FF..FF, 0, 1; min=7, max=12, total=28; signature = XOR of the 3 hashes; runs_done=3.
3. Model never asserts end, TIMEOUT=1000 -> timeout_o=1 after 1000 RUN cycles, then done_o; runs_done=0; min stays all-ones; next start clears timeout_o.
4. runs_i=0 -> exactly one run; runs_done=1.
5. start_i pulsed during RUN, and end_signal held high during RST_UUT -> both ignored; latency is measured from the first RUN cycle.
6. rst=0 asserted in the 3rd RUN cycle of a 3-run sequence -> next cycle: IDLE, busy_o=0, rst_uut_o=1, all statistics 0, no done_o pulse.

Source files
------------

// File: rtl/uut_hash_run_sequencer_if.sv
// Controller/UUT-facing signal bundle of the hash run sequencer.
// master = controller plus UUT side, slave = the sequencer itself.
interface uut_hash_run_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int HASH_WIDTH = 128,
    parameter int CNT_WIDTH  = 32,
    parameter int RUNS_WIDTH = 16
);
    logic                  start_i;
    logic [RUNS_WIDTH-1:0] runs_i;
    logic [DATA_WIDTH-1:0] plaintext_i;
    logic                  incr_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  timeout_o;
    logic                  rst_uut_o;
    logic [DATA_WIDTH-1:0] plaintext_uut_o;
    logic [HASH_WIDTH-1:0] hash_uut_i;
    logic                  end_signal_uut_i;
    logic [HASH_WIDTH-1:0] hash_last_o;
    logic [HASH_WIDTH-1:0] signature_o;
    logic [RUNS_WIDTH-1:0] runs_done_o;
    logic [CNT_WIDTH-1:0]  cycles_last_o;
    logic [CNT_WIDTH-1:0]  cycles_min_o;
    logic [CNT_WIDTH-1:0]  cycles_max_o;
    logic [CNT_WIDTH-1:0]  cycles_total_o;

    modport master (
        output start_i, runs_i, plaintext_i, incr_i, hash_uut_i, end_signal_uut_i,
        input  busy_o, done_o, timeout_o, rst_uut_o, plaintext_uut_o,
               hash_last_o, signature_o, runs_done_o,
               cycles_last_o, cycles_min_o, cycles_max_o, cycles_total_o
    );

    modport slave (
        input  start_i, runs_i, plaintext_i, incr_i, hash_uut_i, end_signal_uut_i,
        output busy_o, done_o, timeout_o, rst_uut_o, plaintext_uut_o,
               hash_last_o, signature_o, runs_done_o,
               cycles_last_o, cycles_min_o, cycles_max_o, cycles_total_o
    );
endinterface

// File: rtl/uut_hash_run_sequencer.sv
// Runs a hash UUT N times (reset, run, capture), folding the hashes into an
// XOR signature and tracking min/max/total latency with a per-run timeout.
module uut_hash_run_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int HASH_WIDTH = 128,
    parameter int CNT_WIDTH  = 32,
    parameter int RUNS_WIDTH = 16,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1048576
) (
    input  logic clk,
    input  logic rst,
    uut_hash_run_sequencer_if.slave bus
);
    localparam int RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_UUT, S_RUN, S_CAPTURE, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [RUNS_WIDTH-1:0] r_runs;
    logic [DATA_WIDTH-1:0] r_pt;
    logic                  r_incr;
    logic [RCW-1:0]        r_rst_cnt;
    logic [CNT_WIDTH-1:0]  r_lat_cnt;
    logic [HASH_WIDTH-1:0] r_hash_last;
    logic [HASH_WIDTH-1:0] r_sig;
    logic [RUNS_WIDTH-1:0] r_runs_done;
    logic [CNT_WIDTH-1:0]  r_last;
    logic [CNT_WIDTH-1:0]  r_min;
    logic [CNT_WIDTH-1:0]  r_max;
    logic [CNT_WIDTH-1:0]  r_total;
    logic                  r_timeout;

    logic                  w_rst_last;
    logic                  w_timeout_hit;
    logic                  w_last_run;
    logic [CNT_WIDTH:0]    w_total_sum;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_rst_uut;

    assign w_rst_last    = (r_rst_cnt == RCW'(RST_CYCLES - 1));
    assign w_timeout_hit = (r_lat_cnt == CNT_WIDTH'(TIMEOUT));
    assign w_last_run    = ((r_runs_done + RUNS_WIDTH'(1)) == r_runs);
    // One extra bit catches the carry that triggers saturation.
    assign w_total_sum   = {1'b0, r_total} + {1'b0, r_lat_cnt};

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start_i) w_next = S_RST_UUT;
            S_RST_UUT: if (w_rst_last) w_next = S_RUN;
            S_RUN: begin
                if (bus.end_signal_uut_i) w_next = S_CAPTURE;
                else if (w_timeout_hit)   w_next = S_DONE;
            end
            S_CAPTURE: w_next = w_last_run ? S_DONE : S_RST_UUT;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_done    = (r_state == S_DONE);
        w_rst_uut = (r_state != S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_runs      <= '0;
            r_pt        <= '0;
            r_incr      <= 1'b0;
            r_rst_cnt   <= '0;
            r_lat_cnt   <= '0;
            r_hash_last <= '0;
            r_sig       <= '0;
            r_runs_done <= '0;
            r_last      <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_total     <= '0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_runs      <= (bus.runs_i == '0) ? RUNS_WIDTH'(1) : bus.runs_i;
                        r_pt        <= bus.plaintext_i;
                        r_incr      <= bus.incr_i;
                        r_rst_cnt   <= '0;
                        r_hash_last <= '0;
                        r_sig       <= '0;
                        r_runs_done <= '0;
                        r_last      <= '0;
                        r_min       <= '1;
                        r_max       <= '0;
                        r_total     <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_RST_UUT: begin
                    r_rst_cnt <= r_rst_cnt + RCW'(1);
                    r_lat_cnt <= CNT_WIDTH'(1);
                end
                S_RUN: begin
                    // The counter freezes on end so CAPTURE sees the latency.
                    if (!bus.end_signal_uut_i) begin
                        r_lat_cnt <= r_lat_cnt + CNT_WIDTH'(1);
                        if (w_timeout_hit) r_timeout <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_hash_last <= bus.hash_uut_i;
                    r_sig       <= r_sig ^ bus.hash_uut_i;
                    r_last      <= r_lat_cnt;
                    if (r_lat_cnt < r_min) r_min <= r_lat_cnt;
                    if (r_lat_cnt > r_max) r_max <= r_lat_cnt;
                    r_total     <= w_total_sum[CNT_WIDTH] ? '1 : w_total_sum[CNT_WIDTH-1:0];
                    r_runs_done <= r_runs_done + RUNS_WIDTH'(1);
                    r_rst_cnt   <= '0;
                    if (!w_last_run && r_incr) r_pt <= r_pt + DATA_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o          = w_busy;
    assign bus.done_o          = w_done;
    assign bus.rst_uut_o       = w_rst_uut;
    assign bus.timeout_o       = r_timeout;
    assign bus.plaintext_uut_o = r_pt;
    assign bus.hash_last_o     = r_hash_last;
    assign bus.signature_o     = r_sig;
    assign bus.runs_done_o     = r_runs_done;
    assign bus.cycles_last_o   = r_last;
    assign bus.cycles_min_o    = r_min;
    assign bus.cycles_max_o    = r_max;
    assign bus.cycles_total_o  = r_total;
endmodule
